// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage of the five-stage MIPS pipeline. Registers
//            the execute-stage bus, selects ALU result or SRAM load data,
//            keeps load data stable across write-back back-pressure, and
//            exports destination / result information to decode.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   1   rising-edge clock
//   reset            in   1   synchronous, active-high
//   ws_allowin       in   1   write-back can accept this cycle
//   ms_allowin       out  1   this stage can accept from execute
//   es_to_ms_valid   in   1   execute presents a valid instruction
//   es_to_ms_bus     in   71  {res_from_mem, gr_we, dest[4:0], alu_result, pc}
//   ms_to_ws_valid   out  1   valid instruction to write-back
//   ms_to_ws_bus     out  70  {gr_we, dest[4:0], final_result, pc}
//   data_sram_rdata  in   32  SRAM read data (valid in first occupancy cycle)
//   out_ms_valid     out  1   stage occupancy
//   ms_dest          out  5   dest when occupied and writing, else 0
//   ms_fwd_bus       out  38  {fwd_valid, dest[4:0], final_result}
// Configuration
//   MS_FWD_EN  defined   : ms_fwd_bus carries the bypass information
//              undefined : ms_fwd_bus tied to zero, no forwarding logic
// ============================================================================
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 71,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       out_ms_valid,
  output logic [4:0]                 ms_dest,
  output logic [37:0]                ms_fwd_bus
);

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
  logic [31:0]                rdata_buf;
  logic                       rdata_held;

  logic        ms_ready_go;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] mem_data;
  logic [31:0] final_result;

  // Field extraction from the registered execute bus
  assign res_from_mem = es_to_ms_bus_r[70];
  assign gr_we        = es_to_ms_bus_r[69];
  assign dest         = es_to_ms_bus_r[68:64];
  assign alu_result   = es_to_ms_bus_r[63:32];
  assign pc           = es_to_ms_bus_r[31:0];

  // Handshake
  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign out_ms_valid   = ms_valid;

  // Occupancy, buffered load data and its ownership flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid   <= 1'b0;
      rdata_held <= 1'b0;
      rdata_buf  <= 32'd0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      // Capture and hold are mutually exclusive: holding needs a stall,
      // and a stall with the stage occupied forces ms_allowin low.
      if (es_to_ms_valid && ms_allowin) begin
        rdata_held <= 1'b0;
      end else if (ms_valid && res_from_mem && !rdata_held && !ws_allowin) begin
        // The SRAM only presents the load data in the first occupancy
        // cycle, so grab it before the port moves on.
        rdata_buf  <= data_sram_rdata;
        rdata_held <= 1'b1;
      end
    end
  end

  // Payload register carries no reset; it is only observed while ms_valid.
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      es_to_ms_bus_r <= es_to_ms_bus;
    end
  end

  assign mem_data     = rdata_held ? rdata_buf : data_sram_rdata;
  assign final_result = res_from_mem ? mem_data : alu_result;

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_dest      = (ms_valid && gr_we) ? dest : 5'd0;

`ifdef MS_FWD_EN
  logic fwd_valid;
  assign fwd_valid  = ms_valid && gr_we && (dest != 5'd0);
  assign ms_fwd_bus = fwd_valid ? {1'b1, dest, final_result} : 38'd0;
`else
  assign ms_fwd_bus = 38'd0;
`endif

endmodule
`default_nettype wire
